apb_slave_mem_param: RTL and testbench
======================================

// Module: apb_slave_mem_param
// PURPOSE
// - Parametrised APB slave fronting an internal word-addressed memory.
// - Successor to the fixed 8-bit slave-with-memory block. Adds:
//   - configurable data width, address width and depth
//   - a programmable wait-state count in place of the external memory-ready input
//   - slave-error reporting for out-of-range addresses
//   - selection of one slave out of an NSEL-wide select bus
// - Sits on the shared APB bus behind the APB master / I2C bridge.
// PARAMETERS
// - DATA_W    8   data bus width in bits; a multiple of 8
// - ADDR_W    8   address bus width in bits
// - DEPTH     64  number of memory words; must be <= 2**ADDR_W
// - NSEL      4   width of the sel bus (number of slaves on the bus)
// - SLAVE_ID  1   index of this slave's bit in sel; must be < NSEL
// - WAIT_W    4   width of the wait_cycles port
// PORTS
// - clk          in   1           bus clock; rising edge
// - rst_n        in   1           asynchronous active-low reset
// - sel          in   NSEL        APB select bus; this slave responds to sel[SLAVE_ID]
// - enable       in   1           APB enable (access phase)
// - write        in   1           1 = write, 0 = read
// - addr         in   ADDR_W      word address
// - wdata        in   DATA_W      write data
// - wait_cycles  in   WAIT_W      wait states to insert per access; sampled in SETUP
// - rdata        out  DATA_W      read data; valid when ready=1 on a read
// - ready        out  1           transfer-complete strobe
// - slverr       out  1           error response; valid only when ready=1
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE; rdata=0, ready=0, slverr=0; wait counter=0.
//   - Memory contents are NOT cleared.
// - FSM states: IDLE, SETUP, ACCESS.
//   - IDLE -> SETUP when sel[SLAVE_ID]=1 and enable=0.
//     Latch addr, write, wdata and wait_cycles into cnt.
//   - SETUP -> ACCESS on the next edge when enable=1.
//     If enable=0 and sel[SLAVE_ID]=1, stay in SETUP and re-latch.
//     If sel[SLAVE_ID]=0, go to IDLE.
//   - ACCESS with cnt!=0: cnt decrements each cycle; ready=0.
//   - ACCESS with cnt==0: ready=1 for exactly one cycle, then IDLE.
//   - Minimum transfer is 2 cycles (setup, then access with ready). Each wait state adds 1 cycle.
// - Write commit:
//   - Memory is written in the same cycle ready=1 is driven, and only if write=1 and addr<DEPTH.
// - Read:
//   - rdata = mem[addr] is registered and presented together with ready=1.
//   - rdata holds its last value otherwise. It is not cleared after a transfer.
// - Out of range (addr >= DEPTH):
//   - slverr=1 alongside ready=1; memory is unchanged.
//   - On a read, rdata=0.
// - Protocol violations:
//   - If sel[SLAVE_ID] or enable drops during ACCESS before ready, abort to IDLE.
//     No write occurs; ready and slverr stay 0.
//   - enable=1 in IDLE without a SETUP phase is ignored.
// - Back-to-back transfers: a new SETUP may begin in the cycle after ready. No idle cycle is required.
// - Reset asserted mid-transfer: return to IDLE immediately. A write not yet committed is lost.
// - Address widths: addr is compared at full ADDR_W width. There is no wrap-around or modulo DEPTH.
// CONFIGURATION
// - Macro APB_SLAVE_MEM_STRB_EN.
// - When defined:
//   - Add input strb [DATA_W/8] (byte write strobes).
//   - strb is latched in SETUP. On a write, only bytes with strb[i]=1 are updated.
//   - strb=0 on a write completes with ready=1, slverr=0 and leaves memory unchanged.
//   - strb is ignored on reads.
// - When undefined: no strb port; every write updates all bytes.
// TESTING
// - Reset:
//   - Assert rst_n=0 mid-ACCESS -> ready=0, slverr=0, rdata=0, state=IDLE.
//   - mem[5] keeps its previously written value.
// - Zero-wait round trip:
//   - wait_cycles=0; write addr=6 wdata=5, then read addr=6.
//   - Each transfer sees ready high on its 2nd cycle. Read returns rdata=5, slverr=0.
// - Wait states:
//   - wait_cycles=5; write addr=5 wdata=4 -> ready rises on the 7th cycle.
//   - Read of addr=5 -> rdata=4. Repeat with wait_cycles=1 (3 cycles) and 3 (5 cycles).
// - Error path:
//   - DEPTH=64; write addr=70 wdata=9 -> ready=1 and slverr=1.
//   - Read addr=70 -> rdata=0, slverr=1. mem[6] (addr 6 = 70 mod 64) is unchanged.
// - Select and abort:
//   - sel=4'b0100 with SLAVE_ID=1 -> no response.
//   - Drop enable during a 3-wait write to addr=3 -> no ready; addr 3 keeps its old value.
// - Strobes (APB_SLAVE_MEM_STRB_EN, DATA_W=16):
//   - mem[2]=16'hAAAA; write wdata=16'h1234 strb=2'b01 -> read returns 16'hAA34.

Source files
------------

// File: rtl/apb_slave_mem_param.sv
// APB slave with an internal word-addressed memory, programmable wait states and
// out-of-range error response. Define APB_SLAVE_MEM_STRB_EN to add byte write strobes.
module apb_slave_mem_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 64,
  parameter int NSEL     = 4,
  parameter int SLAVE_ID = 1,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSEL-1:0]   sel,
  input  logic              enable,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [WAIT_W-1:0] wait_cycles,
`ifdef APB_SLAVE_MEM_STRB_EN
  input  logic [DATA_W/8-1:0] strb,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              slverr
);

  // state  | meaning
  // IDLE   | waiting for sel with enable low
  // SETUP  | request latched, waiting for enable
  // ACCESS | counting wait states; ready pulses when the count is exhausted
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                slverr_q, slverr_d;
  logic [NB-1:0]       strb_q, strb_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   mem_rd;
  logic [DATA_W-1:0]   wmask;
  logic [IDX_W-1:0]    idx;
  logic                sel_me, in_range, latch, complete, mem_we;
  logic                sel_unused;

  assign sel_me     = sel[SLAVE_ID];
  assign sel_unused = ^sel;
  assign idx        = addr_q[IDX_W-1:0];
  assign in_range   = {1'b0, addr_q} < DEPTH_EXT;
  assign mem_rd     = mem[idx];
  assign mem_we     = complete && wr_q && in_range;

`ifdef APB_SLAVE_MEM_STRB_EN
  assign strb_d = latch ? strb : strb_q;
`else
  assign strb_d = '1;
`endif

  always_comb begin
    wmask = '0;
    for (int b = 0; b < NB; b++) wmask[b*8 +: 8] = {8{strb_q[b]}};
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    slverr_d = 1'b0;
    latch    = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_me && !enable) begin
          state_d = ST_SETUP;
          latch   = 1'b1;
        end
      end
      ST_SETUP: begin
        if (!sel_me) begin
          state_d = ST_IDLE;
        end else if (!enable) begin
          latch = 1'b1;
        end else begin
          state_d  = ST_ACCESS;
          complete = (cnt_q == '0);
        end
      end
      ST_ACCESS: begin
        if (ready_q) begin
          state_d = ST_IDLE;
        end else if (!sel_me || !enable) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d    = cnt_q - WAIT_W'(1);
          complete = (cnt_q == WAIT_W'(1));
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (latch) begin
      addr_d  = addr;
      wr_d    = write;
      wdata_d = wdata;
      cnt_d   = wait_cycles;
    end
    // Completion is decided one edge early so ready, rdata and the write land together.
    if (complete) begin
      ready_d  = 1'b1;
      slverr_d = !in_range;
      if (!wr_q) rdata_d = in_range ? mem_rd : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      strb_q   <= strb_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= (mem_rd & ~wmask) | (wdata_q & wmask);
  end

  assign rdata  = rdata_q;
  assign ready  = ready_q;
  assign slverr = slverr_q;

endmodule

// File: tb/tb_apb_slave_mem_param.sv
// Directed bench for apb_slave_mem_param (SLAVE_ID=1, DEPTH=64).
module tb_apb_slave_mem_param;
`ifdef APB_SLAVE_MEM_STRB_EN
  localparam int DW = 16;
`else
  localparam int DW = 8;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    sel = '0;
  logic          enable = 1'b0;
  logic          write = 1'b0;
  logic [7:0]    addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wait_cycles = '0;
`ifdef APB_SLAVE_MEM_STRB_EN
  logic [1:0]    strb = 2'b11;
`endif
  logic [DW-1:0] rdata;
  logic          ready, slverr;

  int n_vec = 0;
  int n_err = 0;

  apb_slave_mem_param #(.DATA_W(DW), .ADDR_W(8), .DEPTH(64), .NSEL(4), .SLAVE_ID(1), .WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .enable(enable), .write(write), .addr(addr),
    .wdata(wdata), .wait_cycles(wait_cycles),
`ifdef APB_SLAVE_MEM_STRB_EN
    .strb(strb),
`endif
    .rdata(rdata), .ready(ready), .slverr(slverr));

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // cyc counts FSM cycles from SETUP to the ready cycle inclusive; 0 means ready never came.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [DW-1:0] wd,
                      input logic [3:0] wc, output logic [DW-1:0] rd, output logic err,
                      output int cyc);
    bit got = 0;
    @(negedge clk);
    sel = 4'b0010; enable = 1'b0; write = wr; addr = a; wdata = wd; wait_cycles = wc;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) begin got = 1; break; end
    end
    if (!got) cyc = 0;
    rd = rdata; err = slverr;
    @(negedge clk);
    sel = '0; enable = 1'b0;
  endtask

  task automatic watch_no_ready(input string tag, input int ncyc);
    bit seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (ready || slverr) seen = 1;
    end
    chk_val(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] rd;
    logic          err;
    int            cyc;

    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_ready", 32'(ready), 32'd0);
    chk_val("rst_slverr", 32'(slverr), 32'd0);
    chk_val("rst_rdata", 32'(rdata), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    xfer(1, 8'd6, DW'(5), 4'd0, rd, err, cyc);
    chk_val("w6_cyc", 32'(cyc), 32'd2);
    chk_val("w6_err", 32'(err), 32'd0);
    xfer(0, 8'd6, '0, 4'd0, rd, err, cyc);
    chk_val("r6_cyc", 32'(cyc), 32'd2);
    chk_val("r6_data", 32'(rd), 32'd5);
    chk_val("r6_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    chk_val("ready_one_cycle", 32'(ready), 32'd0);
    chk_val("rdata_hold", 32'(rdata), 32'd5);

    xfer(1, 8'd5, DW'(4), 4'd5, rd, err, cyc);
    chk_val("w5_wait5_cyc", 32'(cyc), 32'd7);
    chk_val("rdata_hold_wr", 32'(rdata), 32'd5);
    xfer(0, 8'd5, '0, 4'd5, rd, err, cyc);
    chk_val("r5_wait5_cyc", 32'(cyc), 32'd7);
    chk_val("r5_data", 32'(rd), 32'd4);
    xfer(1, 8'd7, DW'(8'h11), 4'd1, rd, err, cyc);
    chk_val("w7_wait1_cyc", 32'(cyc), 32'd3);
    xfer(0, 8'd7, '0, 4'd1, rd, err, cyc);
    chk_val("r7_data", 32'(rd), 32'h11);
    xfer(1, 8'd8, DW'(8'h22), 4'd3, rd, err, cyc);
    chk_val("w8_wait3_cyc", 32'(cyc), 32'd5);
    xfer(0, 8'd8, '0, 4'd3, rd, err, cyc);
    chk_val("r8_wait3_cyc", 32'(cyc), 32'd5);
    chk_val("r8_data", 32'(rd), 32'h22);

    xfer(1, 8'd70, DW'(9), 4'd0, rd, err, cyc);
    chk_val("w70_cyc", 32'(cyc), 32'd2);
    chk_val("w70_err", 32'(err), 32'd1);
    xfer(0, 8'd70, '0, 4'd0, rd, err, cyc);
    chk_val("r70_data", 32'(rd), 32'd0);
    chk_val("r70_err", 32'(err), 32'd1);
    xfer(0, 8'd6, '0, 4'd0, rd, err, cyc);
    chk_val("r6_after_err", 32'(rd), 32'd5);
    chk_val("r6_after_err_e", 32'(err), 32'd0);
    xfer(1, 8'd63, DW'(8'h3F), 4'd0, rd, err, cyc);
    chk_val("w63_err", 32'(err), 32'd0);
    xfer(0, 8'd63, '0, 4'd0, rd, err, cyc);
    chk_val("r63_data", 32'(rd), 32'h3F);
    xfer(1, 8'd64, DW'(1), 4'd0, rd, err, cyc);
    chk_val("w64_err", 32'(err), 32'd1);
    xfer(0, 8'd0, '0, 4'd0, rd, err, cyc);
    chk_val("r0_vs_64", 32'(rd === DW'(1)), 32'd0);

    @(negedge clk);
    sel = 4'b0100; enable = 1'b0; write = 1'b1; addr = 8'd6; wdata = DW'(8'hEE);
    @(negedge clk) enable = 1'b1;
    watch_no_ready("other_sel", 6);
    @(negedge clk);
    sel = 4'b0010; enable = 1'b1;
    watch_no_ready("enable_in_idle", 6);
    @(negedge clk);
    sel = '0; enable = 1'b0;
    xfer(0, 8'd6, '0, 4'd0, rd, err, cyc);
    chk_val("r6_untouched", 32'(rd), 32'd5);

    xfer(1, 8'd3, DW'(8'h33), 4'd0, rd, err, cyc);
    @(negedge clk);
    sel = 4'b0010; enable = 1'b0; write = 1'b1; addr = 8'd3; wdata = DW'(8'hCC); wait_cycles = 4'd3;
    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
    watch_no_ready("abort_no_ready", 8);
    @(negedge clk) sel = '0;
    xfer(0, 8'd3, '0, 4'd0, rd, err, cyc);
    chk_val("r3_after_abort", 32'(rd), 32'h33);

    @(negedge clk);
    sel = 4'b0010; enable = 1'b0; write = 1'b1; addr = 8'd5; wdata = DW'(8'h77); wait_cycles = 4'd3;
    @(negedge clk) enable = 1'b1;
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk_val("midrst_ready", 32'(ready), 32'd0);
    chk_val("midrst_slverr", 32'(slverr), 32'd0);
    chk_val("midrst_rdata", 32'(rdata), 32'd0);
    sel = '0; enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    xfer(0, 8'd5, '0, 4'd0, rd, err, cyc);
    chk_val("r5_after_rst", 32'(rd), 32'd4);
    chk_val("r5_after_rst_cyc", 32'(cyc), 32'd2);

`ifdef APB_SLAVE_MEM_STRB_EN
    strb = 2'b11;
    xfer(1, 8'd2, 16'hAAAA, 4'd0, rd, err, cyc);
    strb = 2'b01;
    xfer(1, 8'd2, 16'h1234, 4'd0, rd, err, cyc);
    xfer(0, 8'd2, '0, 4'd0, rd, err, cyc);
    chk_val("strb_lo", 32'(rd), 32'hAA34);
    strb = 2'b10;
    xfer(1, 8'd2, 16'h5678, 4'd1, rd, err, cyc);
    xfer(0, 8'd2, '0, 4'd0, rd, err, cyc);
    chk_val("strb_hi", 32'(rd), 32'h5634);
    strb = 2'b00;
    xfer(1, 8'd2, 16'hFFFF, 4'd0, rd, err, cyc);
    chk_val("strb0_cyc", 32'(cyc), 32'd2);
    chk_val("strb0_err", 32'(err), 32'd0);
    strb = 2'b01;
    xfer(0, 8'd2, '0, 4'd0, rd, err, cyc);
    chk_val("strb0_data", 32'(rd), 32'h5634);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
